pc_sequencer: RTL
=================

# pc_sequencer

Next-PC controller for the monocycle core. It sits directly in front of the `PC` register and drives its `nextPC` input every cycle. That register has no reset and no enable, so this block supplies both: it forces the reset vector during reset and feeds the current PC back to hold it. Between those cases it sequences fetch through increment, jump/branch redirect, stall hold with a buffered redirect, halt/resume and, optionally, misaligned-target traps.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded while reset is high
- TRAP_VECTOR, 32'h0000_0080, misaligned-target handler address (used only with the trap feature)

Ports:
- clock  in  1  core clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- pc  in  32  current value of the `PC` register
- imem_ready  in  1  instruction memory data valid for `pc`
- stall  in  1  hazard hold from decode
- jump  in  1  unconditional redirect request
- jump_target  in  32  jump destination
- branch_taken  in  1  conditional redirect request
- branch_target  in  32  branch destination
- halt  in  1  halt instruction at `pc` is executing
- resume  in  1  leave HALTED
- next_pc  out  32  combinational; wired to `PC.nextPC`
- fetch_fire  out  1  combinational; instruction at `pc` is consumed this cycle
- state  out  2  registered FSM state
- trap  out  1  one-cycle pulse; tied 0 without the trap feature
- epc  out  32  registered faulting target; tied 0 without the trap feature

## Operation
- Definitions:
  - hold = stall | !imem_ready.
  - redir = jump | branch_taken.
  - tgt = jump ? jump_target : branch_target; jump wins over branch.
- States: RUN=0, WAIT=1, HALTED=2. Reset puts the FSM in RUN.
- While reset is high:
  - next_pc = RESET_VECTOR.
  - fetch_fire = 0.
  - Pending buffer cleared; trap = 0; epc = 0.
- A reset asserted mid-operation discards pending redirects and halt state.
- fetch_fire = (state==RUN || state==WAIT) & !hold & !reset.
- Pending buffer (pend_valid, pend_target):
  - Holds one deferred redirect.
  - A redir during hold loads the buffer; newest overwrites older, so it is 1-deep.
- next_pc priority, highest first:
  1. reset → RESET_VECTOR.
  2. HALTED → pc; if resume, go to RUN.
  3. hold → pc; go to WAIT; capture any redir into the pending buffer.
  4. redir → tgt; clear the pending buffer, since a live redirect beats a stale one.
  5. pend_valid → pend_target; clear the pending buffer.
  6. Otherwise → pc + 4. The addition is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- WAIT to RUN: on the first cycle with hold=0. That cycle applies rule 4, 5 or 6.
- halt with fetch_fire=1:
  - next_pc is chosen per rules 4–6.
  - state goes to HALTED.
  - A simultaneous redir is honoured.
- halt with hold=1 is ignored, because the instruction was not consumed.
- resume: HALTED → RUN with next_pc = pc. The following RUN cycle fetches pc.
- A resume outside HALTED is ignored.
- Without the trap feature, the low 2 bits of every target (tgt or pend_target) are forced to 0 before use.

## Timing
- The path from any input to next_pc is purely combinational. The `PC` register updates on the next posedge, so a redirect takes effect in 1 cycle.
- The first instruction after reset release is at RESET_VECTOR. It can fire in the first cycle after reset deasserts, provided imem_ready=1.
- A buffered redirect takes effect on the posedge following the first cycle with hold=0.
- state, pend_* and epc are registered; trap is registered (one-cycle pulse).

## Configuration
- Macro: PC_SEQ_MISALIGN_TRAP_EN.
- Defined: any applied target with bits[1:0] != 0 causes:
  - next_pc = TRAP_VECTOR;
  - epc <= faulting target;
  - trap = 1 on the following cycle;
  - pending buffer cleared.
- Undefined:
  - No trap logic.
  - Target low bits are masked to 2'b00.
  - trap and epc are constant 0.

## Structure
- Package pc_seq_pkg holds:
  - the state enum (RUN, WAIT, HALTED);
  - PC_STEP=4;
  - default RESET_VECTOR and TRAP_VECTOR constants.
- Sub-module pc_redirect_buf: the 1-deep pending register, with load, clear and overwrite-priority logic.
- Everything else is one always_ff (FSM, epc, trap) plus one always_comb (next_pc mux).

## Test plan
- Reset then run: reset high for 2 cycles, then imem_ready=1 with no requests → next_pc = 0x0, then pc runs 0x4, 0x8, 0xC; fetch_fire=1 each cycle.
- Redirect priority: pc=0x40 with jump=1 (target 0x100) and branch_taken=1 (target 0x200) → next_pc=0x100.
- Buffered redirect:
  - Stimulus: stall=1 for 3 cycles at pc=0x20; branch_taken=1 (target 0x80) in cycle 1; jump=1 (target 0x90) in cycle 2.
  - Response: pc holds 0x20 and state=WAIT throughout; after stall drops, next_pc=0x90.
- Halt/resume:
  - halt at pc=0x30 → next_pc=0x34 and state=HALTED; pc holds 0x34 for 5 cycles.
  - resume → state=RUN, with fetch at 0x34.
- Wrap and mid-run reset:
  - pc=0xFFFF_FFFC → next_pc=0x0.
  - Reset asserted while pend_valid=1 → next_pc=RESET_VECTOR, and the pending target is never applied.
- Misaligned target:
  - With PC_SEQ_MISALIGN_TRAP_EN: jump to 0x102 → next_pc=0x80, epc=0x102, one trap pulse.
  - Without the macro: the same jump → next_pc=0x100.

Source files
------------

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pc_seq_pkg : shared types and constants for the next-PC sequencer        |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pc_redirect_buf : 1-deep deferred redirect register (load beats clear)   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module pc_redirect_buf
  import pc_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_target_i,
  input  logic        clear_i,
  output logic        pend_valid_o,
  output logic [31:0] pend_target_o
);

  logic        valid_q, valid_d;
  logic [31:0] target_q, target_d;

  // A newer redirect simply overwrites whatever was waiting.
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (load_i) begin
      valid_d  = 1'b1;
      target_d = load_target_i;
    end else if (clear_i) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign pend_valid_o  = valid_q;
  assign pend_target_o = target_q;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pc_sequencer : next-PC controller feeding the enable-less PC register.   |
// | Optional misaligned-target trap: define PC_SEQ_MISALIGN_TRAP_EN.  Rev 1.0 |
// +-------------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] next_pc,
  output logic        fetch_fire,
  output logic [1:0]  state,
  output logic        trap,
  output logic [31:0] epc
);

  pc_state_e   state_q, state_d;
  logic        hold, redir, active;
  logic [31:0] tgt, apply_tgt, applied_pc;
  logic        apply_en, pend_load, pend_clear, pend_valid;
  logic [31:0] pend_target;

  assign hold      = stall | ~imem_ready;
  assign redir     = jump | branch_taken;
  assign tgt       = jump ? jump_target : branch_target;
  assign active    = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign apply_tgt = redir ? tgt : pend_target;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic        misalign;
  logic        trap_q;
  logic [31:0] epc_q;
  assign misalign   = apply_en & (apply_tgt[1:0] != 2'b00);
  assign applied_pc = misalign ? TRAP_VECTOR : apply_tgt;
  assign trap       = trap_q;
  assign epc        = epc_q;
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign applied_pc = word_align(apply_tgt);
  assign trap       = 1'b0;
  assign epc        = '0;
`endif

  pc_redirect_buf u_redirect_buf (
    .clock         (clock),
    .reset         (reset),
    .load_i        (pend_load),
    .load_target_i (tgt),
    .clear_i       (pend_clear),
    .pend_valid_o  (pend_valid),
    .pend_target_o (pend_target)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      trap_q  <= misalign;
      if (misalign) epc_q <= apply_tgt;
`endif
    end
  end

  // Halt only counts once the halting instruction has actually been consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (hold)      state_d = ST_WAIT;
        else if (halt) state_d = ST_HALTED;
        else           state_d = ST_RUN;
      end
      ST_HALTED: if (resume) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    next_pc    = pc + PC_STEP;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    apply_en   = 1'b0;
    if (reset) begin
      next_pc = RESET_VECTOR;
    end else if (!active) begin
      next_pc = pc;
    end else if (hold) begin
      next_pc   = pc;
      pend_load = redir;
    end else if (redir || pend_valid) begin
      apply_en   = 1'b1;
      pend_clear = 1'b1;
      next_pc    = applied_pc;
    end
  end

  assign fetch_fire = active & ~hold & ~reset;
  assign state      = state_q;

endmodule
`default_nettype wire
